// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, edge pulses,
// sticky W1C status bits with a programmable edge qualifier, and a combined interrupt.
module multi_edge_detector #(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     sig_in,
  input  logic [2*CH-1:0]   mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CH-1:0]     clr,
  output logic [CH-1:0]     filt_out,
  output logic [CH-1:0]     pos_edge,
  output logic [CH-1:0]     neg_edge,
  output logic [CH-1:0]     any_edge,
  output logic [CH-1:0]     status,
  output logic              irq
);

  logic [CH-1:0]     sync_q [SYNC_STAGES];
  logic [CH-1:0]     sync_d [SYNC_STAGES];
  logic [CH-1:0]     filt_q, filt_d;
  logic [CH-1:0]     filt_dly_q, filt_dly_d;
  logic [FILT_W-1:0] cnt_q [CH];
  logic [FILT_W-1:0] cnt_d [CH];
  logic [CH-1:0]     status_q, status_d;
  logic              irq_q, irq_d;
  logic [CH-1:0]     sync_lvl;
  logic [CH-1:0]     qual_edge;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = sig_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Counter saturates at filt_len via the >= compare, so a lowered filt_len commits next cycle.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_lvl[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_len) begin
        filt_d[i] = sync_lvl[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign filt_dly_d = filt_q;
  assign pos_edge   = filt_q & ~filt_dly_q;
  assign neg_edge   = ~filt_q & filt_dly_q;
  assign any_edge   = filt_q ^ filt_dly_q;

  // A qualified edge in the same cycle as clr keeps the bit set.
  always_comb begin
    qual_edge = '0;
    for (int i = 0; i < CH; i++) begin
      qual_edge[i] = (mode[2*i] & pos_edge[i]) | (mode[2*i+1] & neg_edge[i]);
    end
    status_d = (status_q & ~clr) | qual_edge;
    irq_d    = |status_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q     <= '0;
      filt_dly_q <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
    end
  end

  assign filt_out = filt_q;
  assign status   = status_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed self-checking bench for multi_edge_detector with default parameters
// (CH=8, SYNC_STAGES=2, FILT_W=4); expected values are hand-derived cycle by cycle.
module tb_multi_edge_detector;

  logic        clk;
  logic        rst_n;
  logic [7:0]  sig_in;
  logic [15:0] mode;
  logic [3:0]  filt_len;
  logic [7:0]  clr;
  logic [7:0]  filt_out;
  logic [7:0]  pos_edge;
  logic [7:0]  neg_edge;
  logic [7:0]  any_edge;
  logic [7:0]  status;
  logic        irq;

  int total;
  int bad;

  multi_edge_detector #(.CH(8), .SYNC_STAGES(2), .FILT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .mode     (mode),
    .filt_len (filt_len),
    .clr      (clr),
    .filt_out (filt_out),
    .pos_edge (pos_edge),
    .neg_edge (neg_edge),
    .any_edge (any_edge),
    .status   (status),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [15:0] m,
                               input logic [3:0] fl, input logic [7:0] c);
    sig_in   = s;
    mode     = m;
    filt_len = fl;
    clr      = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with all inputs high, then release and watch the first pos_edge burst.
    rst_n = 1'b0;
    applyStimulus(8'hFF, 16'h0000, 4'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("rst_filt", filt_out, 0);
      checkOutput("rst_any", any_edge, 0);
      checkOutput("rst_status", status, 0);
      checkOutput("rst_irq", irq, 0);
    end
    rst_n = 1'b1;
    tick();
    checkOutput("rel_e1_pos", pos_edge, 0);
    tick();
    checkOutput("rel_e2_filt", filt_out, 0);
    tick();
    checkOutput("rel_e3_pos", pos_edge, 8'hFF);
    checkOutput("rel_e3_filt", filt_out, 8'hFF);
    tick();
    checkOutput("rel_e4_pos", pos_edge, 0);
    checkOutput("rel_e4_filt", filt_out, 8'hFF);
    checkOutput("rel_e4_status", status, 0);
    applyStimulus(8'h00, 16'h0000, 4'd0, 8'h00);
    repeat (4) tick();
    checkOutput("settle_filt", filt_out, 0);
    checkOutput("settle_neg", neg_edge, 0);

    // Glitch filter, filt_len=3: a 3-cycle pulse is dropped.
    applyStimulus(8'h01, 16'h0000, 4'd3, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("glitch3_filt0", filt_out[0], 0);
      checkOutput("glitch3_pos0", pos_edge[0], 0);
      if (k == 3) sig_in = 8'h00;
    end

    // A 4-cycle pulse passes: pos after edge 6, neg after edge 10.
    sig_in = 8'h01;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput("pulse4_filt0", filt_out[0], (k >= 6 && k <= 9) ? 1 : 0);
      checkOutput("pulse4_pos0", pos_edge[0], (k == 6) ? 1 : 0);
      checkOutput("pulse4_neg0", neg_edge[0], (k == 10) ? 1 : 0);
      if (k == 4) sig_in = 8'h00;
    end

    // Mode qualification: ch1 rising, ch2 falling, ch3 both, ch4 rising.
    applyStimulus(8'h0E, 16'h01E4, 4'd0, 8'h00);
    repeat (3) tick();
    checkOutput("mode_rise_pos", pos_edge, 8'h0E);
    checkOutput("mode_rise_status_pre", status, 0);
    tick();
    checkOutput("mode_rise_status", status, 8'h0A);
    checkOutput("mode_rise_irq", irq, 1);
    sig_in = 8'h00;
    repeat (3) tick();
    checkOutput("mode_fall_neg", neg_edge, 8'h0E);
    checkOutput("mode_fall_status_pre", status, 8'h0A);
    tick();
    checkOutput("mode_fall_status", status, 8'h0E);
    clr = 8'h0E;
    tick();
    clr = 8'h00;
    checkOutput("clr_all_status", status, 0);
    checkOutput("clr_all_irq", irq, 0);

    // W1C on ch4 alone, then clr coinciding with a qualified edge.
    sig_in = 8'h10;
    repeat (3) tick();
    checkOutput("w1c_pos4", pos_edge, 8'h10);
    tick();
    checkOutput("w1c_status_set", status, 8'h10);
    checkOutput("w1c_irq_set", irq, 1);
    clr = 8'h10;
    tick();
    clr = 8'h00;
    checkOutput("w1c_status_clr", status, 0);
    checkOutput("w1c_irq_clr", irq, 0);
    applyStimulus(8'h00, 16'h03E4, 4'd0, 8'h00);
    repeat (4) tick();
    checkOutput("both_fall_status", status, 8'h10);
    sig_in = 8'h10;
    repeat (3) tick();
    checkOutput("prio_pos4", pos_edge, 8'h10);
    clr = 8'h10;
    tick();
    clr = 8'h00;
    checkOutput("prio_status", status, 8'h10);
    checkOutput("prio_irq", irq, 1);
    tick();
    checkOutput("prio_status_hold", status, 8'h10);
    clr = 8'hFF;
    tick();
    clr = 8'h00;
    checkOutput("clr_ff_status", status, 0);

    // Lowering filt_len mid-count commits on the next edge.
    applyStimulus(8'h30, 16'h03E4, 4'd15, 8'h00);
    repeat (5) tick();
    checkOutput("flen_filt5_pre", filt_out[5], 0);
    filt_len = 4'd2;
    tick();
    checkOutput("flen_filt5", filt_out[5], 1);
    checkOutput("flen_pos5", pos_edge[5], 1);
    tick();
    checkOutput("flen_status_off", status, 0);
    checkOutput("flen_irq_off", irq, 0);

    // Reset mid-count abandons history; full latency restarts from release.
    applyStimulus(8'h70, 16'h03E4, 4'd7, 8'h00);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_filt", filt_out, 0);
    checkOutput("midrst_pos", pos_edge, 0);
    checkOutput("midrst_status", status, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput("midrst_pos_wait", pos_edge, 0);
      checkOutput("midrst_filt6_wait", filt_out[6], 0);
    end
    tick();
    checkOutput("midrst_pos_e10", pos_edge, 8'h70);
    checkOutput("midrst_filt_e10", filt_out, 8'h70);
    tick();
    checkOutput("midrst_status_e11", status, 8'h10);
    checkOutput("midrst_irq_e11", irq, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel successor to the single-bit edge detector. Each channel has an input synchroniser, a programmable glitch filter and registered rising/falling/any-edge pulses. Each channel also has a sticky status bit that is set by a per-channel edge mode and cleared by write-1-to-clear. A combined interrupt output is provided. The block sits between asynchronous external/GPIO-style inputs and control logic or a CSR block that polls or takes interrupts.

## Interface
- CH, 8: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (min 2).
- FILT_W, 4: width of the glitch-filter length and counters.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset; synchronous, active-low; clears every flop on the clk rising edge where rst_n=0.
- sig_in  in  CH  asynchronous inputs, one per channel.
- mode  in  2*CH  per-channel status qualifier, bits [2i+1:2i] for channel i:
  - 00 off
  - 01 rising
  - 10 falling
  - 11 both
- filt_len  in  FILT_W  required stable cycles minus 1; shared by all channels.
- clr  in  CH  W1C; a 1 in bit i clears status[i].
- filt_out  out  CH  filtered, debounced level.
- pos_edge  out  CH  one-cycle pulse on each filt_out 0->1.
- neg_edge  out  CH  one-cycle pulse on each filt_out 1->0.
- any_edge  out  CH  pos_edge | neg_edge.
- status  out  CH  sticky qualified-edge flags.
- irq  out  1  OR of all status bits.

## Operation
- **Synchroniser:** sig_in[i] passes through SYNC_STAGES flops to give sync[i].
- **Filter state:** each channel holds filt[i] and a FILT_W-bit counter cnt[i].
- **Filter update, each cycle:**
  - If sync[i]==filt[i]: cnt[i]<=0.
  - Else if cnt[i]>=filt_len: filt[i]<=sync[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
- **Filter properties:**
  - A change must persist filt_len+1 consecutive cycles to be accepted.
  - A shorter pulse is discarded and its counter restarts.
  - The counter never wraps; the >= compare caps it.
- **filt_len changes mid-count:** take effect immediately.
  - Lowering filt_len below the current cnt commits on the next cycle.
  - Raising it extends the wait.
- **Edge pulses:** a register filt_d[i] holds the previous filt[i].
  - pos_edge = filt & ~filt_d
  - neg_edge = ~filt & filt_d
  - any_edge = filt ^ filt_d
  - All three are driven only from registers, so they are glitch-free.
- **Edge pulses are unconditional:** mode does not gate them.
- **Status bit, per channel:**
  - A qualified edge is (mode[2i]&pos_edge[i]) | (mode[2i+1]&neg_edge[i]).
  - A qualified edge sets status[i] on the next clock.
  - clr[i]=1 clears status[i] on the next clock.
  - If both occur in the same cycle, set wins and status stays 1.
- **mode=00:** status[i] never sets, but existing status is retained until cleared.
- **Mode changes:** apply from the cycle they are presented.
- **irq:** registered; irq <= |(status_next), so irq follows status in the same cycle.
- **Channel independence:** there is no cross-channel interaction except the shared filt_len.

## Timing
- **Reset values:** every output is 0, as are all sync, filt, filt_d, cnt and status flops.
- **Input high through reset:** an input held at 1 across reset produces a pos_edge after the normal latency.
- **Latency**, for a sig_in change stable before clk edge 1:
  - sync changes after edge SYNC_STAGES.
  - filt_out changes after edge SYNC_STAGES+1+filt_len.
  - The edge pulse is high for exactly the following cycle.
  - status/irq rise after the next edge, i.e. edge SYNC_STAGES+2+filt_len.
- **Defaults:** with SYNC_STAGES=2 and filt_len=0, the pulse follows edge 3 and status follows edge 4.
- **Reset mid-operation:** a pending count is abandoned, all state returns to reset values, and no pulse is emitted from pre-reset history.
- **Rejection window:** with filt_len=L, a sync pulse of L cycles or fewer never reaches filt_out.

## Test plan
- **Reset values:** assert rst_n=0 for 3 cycles while sig_in=0xFF -> all outputs 0 during reset. After release with filt_len=0, all 8 pos_edge bits pulse one cycle after edge 3, and filt_out=0xFF thereafter.
- **Glitch rejection:** filt_len=3, 3-cycle high pulse on sig_in[0] -> no pos_edge, filt_out[0] stays 0. A 4-cycle pulse -> pos_edge[0] after edge 6, then neg_edge[0] 4 cycles after the falling input reaches sync.
- **Mode qualification:** mode ch1=01, ch2=10, ch3=11; toggle sig_in[3:1] up then down.
  - status[1] sets on the rise only.
  - status[2] sets on the fall only.
  - status[3] sets on the first edge.
  - irq=1 after the first qualified edge.
- **W1C priority:** status[4]=1. Pulse clr[4] alone -> status[4]=0 and irq=0 next cycle. Assert clr[4] in the same cycle as a qualified edge -> status[4] remains 1.
- **filt_len change mid-count:** filt_len=15, sig_in[5] high, wait 5 cycles, then set filt_len=2 -> filt_out[5] rises on the next edge.
- **Reset mid-count:** filt_len=7, sig_in[6] high for 4 cycles, assert rst_n=0 for 1 cycle -> no pos_edge before the full 7+1+SYNC_STAGES latency restarts from reset release.
